// File: rtl/tlb_array_pkg.sv
// Shared CSR/TLB types for the TLB array: entry layout, flush opcodes and
// the default entry count.
package tlb_array_pkg;

  localparam int TLBNUM_DEFAULT = 16;
  localparam int TLBNUMSIZE     = $clog2(TLBNUM_DEFAULT);

  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_2M = 6'd21;

  typedef struct packed {
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    logic        e;
  } CompareItem;

  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } PhytranItem;

  typedef struct packed {
    CompareItem cmp;
    PhytranItem pi0;
    PhytranItem pi1;
  } TlbItem;

  typedef enum logic [2:0] {
    FLUSH_ALL0       = 3'd0,
    FLUSH_ALL1       = 3'd1,
    FLUSH_G          = 3'd2,
    FLUSH_NG         = 3'd3,
    FLUSH_NG_ASID    = 3'd4,
    FLUSH_NG_ASID_VA = 3'd5,
    FLUSH_ASID_VA    = 3'd6,
    FLUSH_NOP        = 3'd7
  } FlushOp;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } inv_state_e;

endpackage

// File: rtl/tlb_array_match.sv
// Compares one TLB entry against a virtual address and ASID; also reports
// which half (even/odd page) of the entry the address selects.
module tlb_match
  import tlb_array_pkg::*;
(
  input  CompareItem  entry,
  input  logic [31:0] va,
  input  logic [9:0]  asid,
  output logic        match,
  output logic        va_match,
  output logic        asid_match,
  output logic        odd
);

  logic is_4k_s;
  logic is_2m_s;
  logic unused_va_lo;

  assign is_4k_s      = (entry.ps == PS_4K);
  assign is_2m_s      = (entry.ps == PS_2M);
  assign va_match     = (is_4k_s && (entry.vppn == va[31:13])) ||
                        (is_2m_s && (entry.vppn[18:9] == va[31:22]));
  assign asid_match   = (entry.asid == asid);
  assign match        = entry.e && (entry.g || asid_match) && va_match;
  assign odd          = is_2m_s ? va[21] : va[12];
  assign unused_va_lo = ^va[11:0];

endmodule

// File: rtl/tlb_array.sv
// Fully associative TLB: two registered lookup ports, indexed/fill write,
// registered read-back and a one-entry-per-cycle invalidate sweep.
module tlb_array
  import tlb_array_pkg::*;
#(
  parameter  int TLBNUM = TLBNUM_DEFAULT,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s0_req,
  input  logic [31:0]     s0_va,
  input  logic            s1_req,
  input  logic [31:0]     s1_va,
  input  logic [9:0]      s_asid,
  output logic            s0_found,
  output logic [IDXW-1:0] s0_index,
  output logic [5:0]      s0_ps,
  output PhytranItem      s0_pi,
  output logic            s1_found,
  output logic [IDXW-1:0] s1_index,
  output logic [5:0]      s1_ps,
  output PhytranItem      s1_pi,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic            w_fill,
  input  logic [IDXW-1:0] w_index,
  input  TlbItem          w_item,
  input  logic [IDXW-1:0] r_index,
  output TlbItem          r_item,
  input  logic            inv_valid,
  input  logic [2:0]      inv_op,
  input  logic [9:0]      inv_asid,
  input  logic [31:0]     inv_va,
  output logic            inv_busy,
  output logic            inv_done
);

  TlbItem            mem_q [TLBNUM];
  TlbItem            mem_d [TLBNUM];
  logic [TLBNUM-1:0] e_q, e_d;
  logic [IDXW-1:0]   fill_q, fill_d;
  logic [IDXW-1:0]   sweep_idx_q, sweep_idx_d;
  inv_state_e        state_q, state_d;
  FlushOp            inv_op_q, inv_op_d;
  logic [9:0]        inv_asid_q, inv_asid_d;
  logic [31:0]       inv_va_q, inv_va_d;
  logic              inv_done_q, inv_done_d;
  TlbItem            r_item_q, r_item_d;

  logic              s0_found_q, s0_found_d, s1_found_q, s1_found_d;
  logic [IDXW-1:0]   s0_index_q, s0_index_d, s1_index_q, s1_index_d;
  logic [5:0]        s0_ps_q, s0_ps_d, s1_ps_q, s1_ps_d;
  PhytranItem        s0_pi_q, s0_pi_d, s1_pi_q, s1_pi_d;

  CompareItem        cmp_s [TLBNUM];
  logic [TLBNUM-1:0] m0_s, m1_s, odd0_s, odd1_s;
  logic [TLBNUM-1:0] unused_va_m0, unused_va_m1, unused_asid_m0, unused_asid_m1;
  logic              hit0_s, hit1_s;
  logic [IDXW-1:0]   idx0_s, idx1_s;
  logic              w_en_s;
  logic [IDXW-1:0]   w_idx_s;
  logic              sw_va_m_s, sw_asid_m_s, sw_g_s, clr_s;
  logic              unused_sw_match, unused_sw_odd;

  assign w_en_s  = w_valid && (state_q == ST_IDLE);
  assign w_idx_s = w_fill ? fill_q : w_index;

  // Effective compare view: the reset E flop gates the stored E bit, so stale
  // non-reset contents can never hit after reset.
  always_comb begin
    for (int i = 0; i < TLBNUM; i++) begin
      cmp_s[i]   = mem_q[i].cmp;
      cmp_s[i].e = e_q[i] && mem_q[i].cmp.e;
    end
  end

  for (genvar i = 0; i < TLBNUM; i++) begin : g_entry
    tlb_match u_m0 (
      .entry(cmp_s[i]), .va(s0_va), .asid(s_asid), .match(m0_s[i]),
      .va_match(unused_va_m0[i]), .asid_match(unused_asid_m0[i]), .odd(odd0_s[i])
    );
    tlb_match u_m1 (
      .entry(cmp_s[i]), .va(s1_va), .asid(s_asid), .match(m1_s[i]),
      .va_match(unused_va_m1[i]), .asid_match(unused_asid_m1[i]), .odd(odd1_s[i])
    );
  end

  tlb_match u_sweep (
    .entry(cmp_s[sweep_idx_q]), .va(inv_va_q), .asid(inv_asid_q),
    .match(unused_sw_match), .va_match(sw_va_m_s), .asid_match(sw_asid_m_s),
    .odd(unused_sw_odd)
  );

  // Lowest matching index wins on each port; a miss forces all fields to zero.
  always_comb begin
    hit0_s = 1'b0;
    idx0_s = '0;
    hit1_s = 1'b0;
    idx1_s = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (m0_s[i]) begin
        hit0_s = 1'b1;
        idx0_s = IDXW'(i);
      end
      if (m1_s[i]) begin
        hit1_s = 1'b1;
        idx1_s = IDXW'(i);
      end
    end
    s0_found_d = s0_req ? hit0_s : s0_found_q;
    s0_index_d = s0_req ? idx0_s : s0_index_q;
    s0_ps_d    = s0_req ? (hit0_s ? cmp_s[idx0_s].ps : 6'd0) : s0_ps_q;
    s0_pi_d    = s0_req ? (hit0_s ? (odd0_s[idx0_s] ? mem_q[idx0_s].pi1 : mem_q[idx0_s].pi0) : '0)
                        : s0_pi_q;
    s1_found_d = s1_req ? hit1_s : s1_found_q;
    s1_index_d = s1_req ? idx1_s : s1_index_q;
    s1_ps_d    = s1_req ? (hit1_s ? cmp_s[idx1_s].ps : 6'd0) : s1_ps_q;
    s1_pi_d    = s1_req ? (hit1_s ? (odd1_s[idx1_s] ? mem_q[idx1_s].pi1 : mem_q[idx1_s].pi0) : '0)
                        : s1_pi_q;
  end

  always_comb begin
    sw_g_s = cmp_s[sweep_idx_q].g;
    clr_s  = 1'b0;
    case (inv_op_q)
      FLUSH_ALL0, FLUSH_ALL1: clr_s = 1'b1;
      FLUSH_G:                clr_s = sw_g_s;
      FLUSH_NG:               clr_s = !sw_g_s;
      FLUSH_NG_ASID:          clr_s = !sw_g_s && sw_asid_m_s;
      FLUSH_NG_ASID_VA:       clr_s = !sw_g_s && sw_asid_m_s && sw_va_m_s;
      FLUSH_ASID_VA:          clr_s = (sw_g_s || sw_asid_m_s) && sw_va_m_s;
      default:                clr_s = 1'b0;
    endcase
  end

  // Invalidate FSM; inv_done is registered so it is set one step ahead.
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    inv_op_d    = inv_op_q;
    inv_asid_d  = inv_asid_q;
    inv_va_d    = inv_va_q;
    inv_done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (inv_valid) begin
          inv_op_d    = FlushOp'(inv_op);
          inv_asid_d  = inv_asid;
          inv_va_d    = inv_va;
          sweep_idx_d = '0;
          if (FlushOp'(inv_op) == FLUSH_NOP) begin
            inv_done_d = 1'b1;
          end else begin
            state_d = ST_SWEEP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        sweep_idx_d = sweep_idx_q + IDXW'(1);
        inv_done_d  = (sweep_idx_q == IDXW'(TLBNUM - 2));
        if (sweep_idx_q == IDXW'(TLBNUM - 1)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SWEEP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    e_d = e_q;
    if (w_en_s) begin
      e_d[w_idx_s] = w_item.cmp.e;
    end else if ((state_q == ST_SWEEP) && clr_s) begin
      e_d[sweep_idx_q] = 1'b0;
    end else begin
      e_d = e_q;
    end
    for (int i = 0; i < TLBNUM; i++) begin
      mem_d[i] = (w_en_s && (w_idx_s == IDXW'(i))) ? w_item : mem_q[i];
    end
    fill_d         = fill_q + IDXW'(1);
    r_item_d       = mem_q[r_index];
    r_item_d.cmp.e = cmp_s[r_index].e;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q         <= '0;
      fill_q      <= '0;
      sweep_idx_q <= '0;
      state_q     <= ST_IDLE;
      inv_op_q    <= FLUSH_NOP;
      inv_asid_q  <= 10'd0;
      inv_va_q    <= 32'd0;
      inv_done_q  <= 1'b0;
      r_item_q    <= '0;
      s0_found_q  <= 1'b0;
      s0_index_q  <= '0;
      s0_ps_q     <= 6'd0;
      s0_pi_q     <= '0;
      s1_found_q  <= 1'b0;
      s1_index_q  <= '0;
      s1_ps_q     <= 6'd0;
      s1_pi_q     <= '0;
    end else begin
      e_q         <= e_d;
      fill_q      <= fill_d;
      sweep_idx_q <= sweep_idx_d;
      state_q     <= state_d;
      inv_op_q    <= inv_op_d;
      inv_asid_q  <= inv_asid_d;
      inv_va_q    <= inv_va_d;
      inv_done_q  <= inv_done_d;
      r_item_q    <= r_item_d;
      s0_found_q  <= s0_found_d;
      s0_index_q  <= s0_index_d;
      s0_ps_q     <= s0_ps_d;
      s0_pi_q     <= s0_pi_d;
      s1_found_q  <= s1_found_d;
      s1_index_q  <= s1_index_d;
      s1_ps_q     <= s1_ps_d;
      s1_pi_q     <= s1_pi_d;
    end
  end

  assign s0_found = s0_found_q;
  assign s0_index = s0_index_q;
  assign s0_ps    = s0_ps_q;
  assign s0_pi    = s0_pi_q;
  assign s1_found = s1_found_q;
  assign s1_index = s1_index_q;
  assign s1_ps    = s1_ps_q;
  assign s1_pi    = s1_pi_q;
  assign r_item   = r_item_q;
  assign inv_busy = (state_q == ST_SWEEP);
  assign inv_done = inv_done_q;
  assign w_ready  = (state_q == ST_IDLE);

endmodule

// File: tb/tb_tlb_array.sv
// Directed self-checking bench for tlb_array (TLBNUM = 16).
module tb_tlb_array;
  import tlb_array_pkg::*;

  logic        clk, rst;
  logic        s0_req, s1_req;
  logic [31:0] s0_va, s1_va;
  logic [9:0]  s_asid;
  logic        s0_found, s1_found;
  logic [3:0]  s0_index, s1_index;
  logic [5:0]  s0_ps, s1_ps;
  PhytranItem  s0_pi, s1_pi;
  logic        w_valid, w_ready, w_fill;
  logic [3:0]  w_index, r_index;
  TlbItem      w_item, r_item;
  logic        inv_valid;
  logic [2:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [31:0] inv_va;
  logic        inv_busy, inv_done;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] fill_model;

  tlb_array dut (
    .clk(clk), .reset(rst),
    .s0_req(s0_req), .s0_va(s0_va), .s1_req(s1_req), .s1_va(s1_va), .s_asid(s_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_ps(s0_ps), .s0_pi(s0_pi),
    .s1_found(s1_found), .s1_index(s1_index), .s1_ps(s1_ps), .s1_pi(s1_pi),
    .w_valid(w_valid), .w_ready(w_ready), .w_fill(w_fill), .w_index(w_index), .w_item(w_item),
    .r_index(r_index), .r_item(r_item),
    .inv_valid(inv_valid), .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
    .inv_busy(inv_busy), .inv_done(inv_done)
  );

  always #5 clk = ~clk;

  // Reference fill counter: free-running from reset, wraps at 16.
  always @(posedge clk or posedge rst) begin
    if (rst) fill_model <= 4'd0;
    else     fill_model <= fill_model + 4'd1;
  end

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic TlbItem mk(input logic e, input logic g, input logic [9:0] asid,
                                input logic [5:0] ps, input logic [18:0] vppn,
                                input logic [19:0] ppn0, input logic [19:0] ppn1);
    TlbItem it;
    it.cmp.e    = e;
    it.cmp.g    = g;
    it.cmp.asid = asid;
    it.cmp.ps   = ps;
    it.cmp.vppn = vppn;
    it.pi0      = '{ppn: ppn0, plv: 2'd0, mat: 2'd1, d: 1'b1, v: 1'b1};
    it.pi1      = '{ppn: ppn1, plv: 2'd3, mat: 2'd0, d: 1'b0, v: 1'b1};
    return it;
  endfunction

  task automatic wr(input logic [3:0] idx, input TlbItem it);
    w_valid = 1'b1; w_fill = 1'b0; w_index = idx; w_item = it;
    step();
    w_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] idx, output TlbItem it);
    r_index = idx;
    step();
    it = r_item;
  endtask

  task automatic lk0(input logic [31:0] va);
    s0_req = 1'b1; s0_va = va;
    step();
    s0_req = 1'b0;
  endtask

  task automatic run_inv(input logic [2:0] op, input logic [9:0] asid, input logic [31:0] va,
                         output int busy, output int done, output int wrbad, output logic first_done);
    inv_valid = 1'b1; inv_op = op; inv_asid = asid; inv_va = va;
    step();
    inv_valid = 1'b0;
    busy = 0; done = 0; wrbad = 0; first_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (inv_busy) busy++;
      if (inv_done) done++;
      if (inv_busy && w_ready) wrbad++;
      if (k == 0) first_done = inv_done;
      step();
    end
  endtask

  TlbItem     it, e3;
  PhytranItem exp_pi;
  int         busy, done, wrbad, bad;
  logic       fd;
  logic [18:0] exp_vppn [16];

  initial begin
    clk = 1'b0; rst = 1'b1;
    s0_req = 1'b0; s1_req = 1'b0; s0_va = 32'd0; s1_va = 32'd0; s_asid = 10'd0;
    w_valid = 1'b0; w_fill = 1'b0; w_index = 4'd0; w_item = '0; r_index = 4'd0;
    inv_valid = 1'b0; inv_op = 3'd0; inv_asid = 10'd0; inv_va = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_found", s0_found, 1'b0);
    check("rst_index", s0_index, 4'd0);
    check("rst_ritem", r_item, '0);
    check("rst_busy", inv_busy, 1'b0);
    check("rst_done", inv_done, 1'b0);
    check("rst_wready", w_ready, 1'b1);
    rst = 1'b0;
    step();

    // Basic 4K hit, va[12]=1 selects PI1
    e3 = mk(1'b1, 1'b0, 10'd5, PS_4K, 19'h12345, 20'h11111, 20'h22222);
    wr(4'd3, e3);
    s_asid = 10'd5;
    lk0(32'h2468B000);
    check("hit4k_found", s0_found, 1'b1);
    check("hit4k_index", s0_index, 4'd3);
    check("hit4k_ps", s0_ps, 6'd12);
    check("hit4k_pi", s0_pi, e3.pi1);
    lk0(32'h2468A000);
    check("hit4k_pi0", s0_pi, e3.pi0);

    s_asid = 10'd6;
    lk0(32'h2468B000);
    check("asid_miss_found", s0_found, 1'b0);
    check("asid_miss_pi", s0_pi, '0);
    e3.cmp.g = 1'b1;
    wr(4'd3, e3);
    lk0(32'h2468B000);
    check("global_found", s0_found, 1'b1);

    // 2M pages at idx0 and idx7: lowest index wins, va[21]=0 -> PI0
    it = mk(1'b1, 1'b1, 10'd0, PS_2M, 19'h1A200, 20'h0AAAA, 20'h0BBBB);
    wr(4'd0, it);
    wr(4'd7, mk(1'b1, 1'b1, 10'd0, PS_2M, 19'h1A200, 20'h0CCCC, 20'h0DDDD));
    s1_req = 1'b1; s1_va = 32'h34400000;
    lk0(32'h34400000);
    s1_req = 1'b0;
    check("hit2m_index", s0_index, 4'd0);
    check("hit2m_pi", s0_pi, it.pi0);
    check("hit2m_ps", s0_ps, 6'd21);
    check("s1_found", s1_found, 1'b1);
    check("s1_index", s1_index, 4'd0);

    // No request: outputs hold
    s0_va = 32'h0; s1_va = 32'h0;
    step();
    check("hold_found", s0_found, 1'b1);
    check("hold_index", s0_index, 4'd0);

    // Lookup and write same edge see pre-write contents
    s0_req = 1'b1; s0_va = 32'h34400000;
    w_valid = 1'b1; w_fill = 1'b0; w_index = 4'd0; w_item = '0;
    step();
    w_valid = 1'b0; s0_req = 1'b0;
    check("samedge_index", s0_index, 4'd0);
    lk0(32'h34400000);
    check("after_clr_index", s0_index, 4'd7);

    rd(4'd3, it);
    check("rd_idx3", it, e3);

    // 16 mixed entries, flush non-global ASID 5
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), mk(1'b1, i[0], i[1] ? 10'd5 : 10'd6, PS_4K, 19'(i), 20'(i), 20'(i + 256)));
    end
    run_inv(3'd4, 10'd5, 32'd0, busy, done, wrbad, fd);
    check("op4_busy_cycles", 96'(busy), 96'd16);
    check("op4_done_pulses", 96'(done), 96'd1);
    check("op4_wready_busy", 96'(wrbad), 96'd0);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), it);
      if (it.cmp.e !== ((i % 4) != 2)) bad++;
    end
    check("op4_e_bits", 96'(bad), 96'd0);

    // Non-global ASID 6 at VA page 4 only
    run_inv(3'd5, 10'd6, 32'h00008000, busy, done, wrbad, fd);
    check("op5_done", 96'(done), 96'd1);
    rd(4'd4, it);
    check("op5_e4", it.cmp.e, 1'b0);
    rd(4'd0, it);
    check("op5_e0", it.cmp.e, 1'b1);
    rd(4'd5, it);
    check("op5_e5", it.cmp.e, 1'b1);

    run_inv(3'd7, 10'd0, 32'd0, busy, done, wrbad, fd);
    check("op7_busy", 96'(busy), 96'd0);
    check("op7_done", 96'(done), 96'd1);
    check("op7_first", fd, 1'b1);
    rd(4'd1, it);
    check("op7_keeps", it.cmp.e, 1'b1);

    // Fill path follows the free-running counter, with wrap
    w_valid = 1'b1; w_fill = 1'b1; w_index = 4'd0;
    for (int k = 0; k < 20; k++) begin
      w_item = mk(1'b1, 1'b1, 10'd0, PS_4K, 19'(100 + k), 20'd0, 20'd0);
      exp_vppn[fill_model] = 19'(100 + k);
      step();
    end
    w_valid = 1'b0; w_fill = 1'b0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), it);
      if (it.cmp.vppn !== exp_vppn[i]) bad++;
    end
    check("fill_vppn", 96'(bad), 96'd0);

    // Reset in the middle of a sweep
    inv_valid = 1'b1; inv_op = 3'd0;
    step();
    inv_valid = 1'b0;
    busy = 0; done = 0;
    for (int k = 0; k < 8; k++) begin
      if (inv_busy) busy++;
      if (inv_done) done++;
      step();
    end
    check("mid_busy_seen", 96'(busy), 96'd8);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", inv_busy, 1'b0);
    check("mid_rst_done", inv_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (inv_done) done++;
      step();
    end
    check("mid_no_done", 96'(done), 96'd0);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), it);
      if (it.cmp.e !== 1'b0) bad++;
    end
    check("mid_all_e0", 96'(bad), 96'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tlb_array.md
TLB_ARRAY -- requirements
Module: tlb_array

Interface
REQ-001 TLBNUM, 16, number of entries; power of two, 4..64; IDXW = clog2(TLBNUM).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 s0_req / s1_req  in  1  lookup request, fetch port / data port.
REQ-005 s0_va / s1_va  in  32  virtual address to translate.
REQ-006 s_asid  in  10  current ASID, shared by both ports and write-free.
REQ-007 s0_found / s1_found  out  1  hit flag, registered.
REQ-008 s0_index / s1_index  out  IDXW  hit entry index, registered.
REQ-009 s0_ps / s1_ps  out  6  page size of the hit entry.
REQ-010 s0_pi / s1_pi  out  PhytranItem  selected even/odd half of the hit entry.
REQ-011 w_valid  in  1  write request (TLBWR / TLBFILL); w_ready  out  1  write accepted.
REQ-012 w_fill  in  1  1 = use internal fill index, 0 = use w_index.
REQ-013 w_index  in  IDXW; w_item  in  TlbItem  entry to write.
REQ-014 r_index  in  IDXW; r_item  out  TlbItem  registered read data (TLBRD).
REQ-015 inv_valid  in  1; inv_op  in  3 (FlushOp); inv_asid  in  10; inv_va  in  32.
REQ-016 inv_busy  out  1  sweep in progress; inv_done  out  1  one-cycle completion pulse.

Function
REQ-017 Entry i matches when E=1, (G=1 or ASID=s_asid), and VPPN equals va[31:13] (PS=12) or VPPN[18:9] equals va[31:22] (PS=21).
REQ-018 Odd/even half selected by va[12] when PS=12, va[21] when PS=21; 1 selects PI1.
REQ-019 Lookup latency exactly one cycle; outputs update only in cycles after s*_req=1, otherwise hold.
REQ-020 Multiple matches: lowest index wins; found=0 forces index, ps and pi to zero.
REQ-021 Lookups are served every cycle, including during an invalidate sweep; each sees array contents as of the lookup edge.
REQ-022 Fill index: free-running IDXW-bit counter, increments every cycle, wraps TLBNUM-1 -> 0; sampled on accepted fill.
REQ-023 w_ready = !inv_busy; write commits on the edge where w_valid && w_ready; writing E=0 is legal.
REQ-024 r_item = entry[r_index], registered one cycle; reflects a same-edge write only on the following read.
REQ-025 Invalidate FSM states IDLE -> SWEEP -> IDLE; inv_valid in IDLE latches op/asid/va and enters SWEEP next cycle.
REQ-026 SWEEP visits one entry per cycle, index 0..TLBNUM-1, clearing E when the op condition holds; returns to IDLE after the last index; inv_done pulses in the cycle of the final sweep step.
REQ-027 Op conditions: 0,1 all; 2 G=1; 3 G=0; 4 G=0 && ASID match; 5 G=0 && ASID match && VA match; 6 (G=1 or ASID match) && VA match; VA match uses the REQ-017 rule with inv_va.
REQ-028 inv_op 7: no entry cleared; FSM skips SWEEP and pulses inv_done one cycle after acceptance.
REQ-029 inv_busy = 1 in SWEEP; inv_valid while busy is ignored.
REQ-030 A write and sweep cannot coincide (REQ-023); a lookup and a write on the same edge returns pre-write contents.

Reset
REQ-031 Reset clears all E bits, fill counter = 0, FSM = IDLE, all found/index/ps/pi/r_item/inv_busy/inv_done = 0.
REQ-032 Reset asserted mid-sweep aborts the sweep immediately; no inv_done pulse.
REQ-033 Non-E entry fields are not reset.

Structure
REQ-034 TLBNUM default, TlbItem/CompareItem/PhytranItem and FlushOp live in the shared CSR/TLB package; TLBNUMSIZE derives from TLBNUM there.
REQ-035 One sub-module tlb_match: one entry + va + asid in, match and odd-select out; instantiated per entry per port and once for the sweep.

Verification
REQ-036 Write idx3 {E=1,G=0,ASID=5,PS=12,VPPN=0x12345}; s0_va=0x2468B000, asid=5 -> next cycle found=1, index=3, pi=PI1.
REQ-037 Same entry, asid=6 -> found=0; rewrite with G=1 -> found=1.
REQ-038 PS=21 entry VPPN=0x1A200 at idx0 and idx7; va=0x34400000 -> index=0, pi=PI0 (va[21]=0).
REQ-039 TLBNUM=16, 16 entries mixed G/ASID, inv_op=4 asid=5 -> inv_busy 16 cycles, only G=0 ASID=5 entries cleared, inv_done one pulse; w_ready=0 throughout.
REQ-040 Fill 20 consecutive cycles with w_fill=1 -> indices follow counter with wrap 15 -> 0; reset at sweep cycle 8 -> busy=0, no inv_done, all E=0.
